// File: rtl/pci_target_ctrl.sv
// PCI target controller: one 4-word register window at BASE_ADDR, single-clock FSM.
// Define PCI_TGT_DISCONNECT_EN to disconnect (stop) at word 3 instead of wrapping to word 0.
module pci_target_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame,
    input  logic        irdy,
    input  logic [3:0]  C_BE,
    inout  wire  [31:0] AD,
    output logic        devsel,
    output logic        trdy,
    output logic        stop,
    output logic        R_W,
    output logic [7:0]  xfer_cnt
);

    typedef enum logic [1:0] {IDLE, DECODE, DATA, TURN} state_t;

    state_t      state, state_nxt;
    logic        frame_q;
    logic [1:0]  idx;
    logic [31:0] regs [4];
    logic        addr_phase;
    logic        hit;
    logic        xfer;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    function automatic logic [1:0] idx_next(input logic [1:0] i);
`ifdef PCI_TGT_DISCONNECT_EN
        return (i == 2'd3) ? i : i + 2'd1;
`else
        return i + 2'd1;
`endif
    endfunction

    // Address phase is only recognised on a fresh FRAME assertion while idle.
    assign addr_phase = (state == IDLE) && frame && !frame_q;
    assign hit        = (AD[31:4] == BASE_ADDR[31:4]) && ((C_BE == 4'b0010) || (C_BE == 4'b0011));
    assign xfer       = (state == DATA) && irdy;

    assign AD = ((state == DATA) && !R_W) ? regs[idx] : 32'bz;

    always_comb begin
        state_nxt = state;
        devsel    = 1'b0;
        trdy      = 1'b0;
        stop      = 1'b0;
        case (state)
            IDLE: begin
                if (addr_phase && hit)
                    state_nxt = DECODE;
            end
            DECODE: begin
                devsel    = 1'b1;
                state_nxt = DATA;
            end
            DATA: begin
                devsel = 1'b1;
                trdy   = 1'b1;
`ifdef PCI_TGT_DISCONNECT_EN
                stop = (idx == 2'd3);
                if (!frame || (xfer && idx == 2'd3))
                    state_nxt = TURN;
`else
                if (!frame)
                    state_nxt = TURN;
`endif
            end
            TURN: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            frame_q  <= 1'b0;
            idx      <= 2'd0;
            R_W      <= 1'b0;
            xfer_cnt <= 8'd0;
            for (int w = 0; w < 4; w++)
                regs[w] <= 32'h0;
        end else begin
            state   <= state_nxt;
            frame_q <= frame;
            if (addr_phase && hit) begin
                idx      <= AD[3:2];
                R_W      <= C_BE[0];
                xfer_cnt <= 8'd0;
            end
            if (xfer) begin
                // Byte enables are active-low during the data phase.
                if (R_W) begin
                    for (int b = 0; b < 4; b++)
                        if (!C_BE[b])
                            regs[idx][8*b +: 8] <= AD[8*b +: 8];
                end
                idx      <= idx_next(idx);
                xfer_cnt <= sat_inc(xfer_cnt);
            end
        end
    end

endmodule
